// File: rtl/axi_reg_bank.sv
// AXI-style register bank: NUM_REGS words of DATA_W bits with independent write and read paths.
// Writes commit once both the address and data slots are held; reads answer in a single edge.
module axi_reg_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                areset,

    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,

    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    input  logic                wvalid_i,
    output logic                wready_o,

    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,

    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic                arvalid_i,
    output logic                arready_o,

    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned HI     = LSB + IDX_W;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    // Any set bit above the index field, or an index past the last register, is out of range.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] upper;
        idx   = addr[LSB +: IDX_W];
        upper = addr >> HI;
        return (32'(idx) < NUM_REGS) && (upper == '0);
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              aw_full_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [ID_W-1:0]   aw_id_q;

    logic              w_full_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              w_last_q;

    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    logic              rvalid_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic             wr_ok;
    logic             rd_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        awready_o = !aw_full_q;
        wready_o  = !w_full_q;
        arready_o = !rvalid_q || rready_i;
        aw_hs     = awvalid_i && !aw_full_q;
        w_hs      = wvalid_i && !w_full_q;
        ar_hs     = arvalid_i && arready_o;
        commit    = aw_full_q && w_full_q && (!bvalid_q || bready_i);
        wr_idx    = aw_addr_q[LSB +: IDX_W];
        rd_idx    = araddr_i[LSB +: IDX_W];
        wr_ok     = addr_in_range(aw_addr_q) && w_last_q;
        rd_ok     = addr_in_range(araddr_i);
    end

    assign bvalid_o = bvalid_q;
    assign bid_o    = bid_q;
    assign bresp_o  = bresp_q;
    assign rvalid_o = rvalid_q;
    assign rid_o    = rid_q;
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;

    // Register file: byte-enabled update on a successful commit.
    always_ff @(posedge clk) begin
        if (areset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (w_strb_q[i]) begin
                    regs_q[wr_idx][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

    // Write path: address/data slots and the response register.
    always_ff @(posedge clk) begin
        if (areset) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_last_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RespOkay;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= awaddr_i;
                aw_id_q   <= awid_i;
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end

            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
                w_last_q <= wlast_i;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bid_q    <= aw_id_q;
                bresp_q  <= wr_ok ? RespOkay : RespSlverr;
            end else if (bready_i) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read path: data is sampled from the register file before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
            rlast_q  <= 1'b0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rid_q    <= arid_i;
            rlast_q  <= 1'b1;
            rdata_q  <= rd_ok ? regs_q[rd_idx] : '0;
            rresp_q  <= rd_ok ? RespOkay : RespSlverr;
        end else if (rready_i) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_reg_bank.sv
// Self-checking bench for axi_reg_bank: directed scenarios plus randomized traffic,
// with expected B/R responses queued by a word-array model and checked by a monitor.
module tb_axi_reg_bank;

    localparam int NUM_REGS = 8;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awid_i;
    logic [31:0] awaddr_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;

    axi_reg_bank #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .ID_W    (4),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .awid_i   (awid_i),
        .awaddr_i (awaddr_i),
        .awvalid_i(awvalid_i),
        .awready_o(awready_o),
        .wdata_i  (wdata_i),
        .wstrb_i  (wstrb_i),
        .wlast_i  (wlast_i),
        .wvalid_i (wvalid_i),
        .wready_o (wready_o),
        .bid_o    (bid_o),
        .bresp_o  (bresp_o),
        .bvalid_o (bvalid_o),
        .bready_i (bready_i),
        .arid_i   (arid_i),
        .araddr_i (araddr_i),
        .arvalid_i(arvalid_i),
        .arready_o(arready_o),
        .rid_o    (rid_o),
        .rdata_o  (rdata_o),
        .rresp_o  (rresp_o),
        .rlast_o  (rlast_o),
        .rvalid_o (rvalid_o),
        .rready_i (rready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] mem [NUM_REGS];
    int          checks   = 0;
    int          failures = 0;
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        return (addr >> 2) < NUM_REGS;
    endfunction

    task automatic exp_write(input logic [3:0] id, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input bit last);
        bit ok;
        ok = in_range(addr) && last;
        exp_b.push_back('{id: id, resp: ok ? 2'b00 : 2'b10});
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mem[addr >> 2][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    task automatic exp_read(input logic [3:0] id, input logic [31:0] addr);
        if (in_range(addr)) exp_r.push_back('{id: id, data: mem[addr >> 2], resp: 2'b00});
        else exp_r.push_back('{id: id, data: 32'h0, resp: 2'b10});
    endtask

    // Each transfer task starts just after a rising edge and returns just after its handshake edge.
    task automatic aw_xfer(input logic [3:0] id, input logic [31:0] addr);
        int n = 0;
        awid_i = id; awaddr_i = addr; awvalid_i = 1'b1;
        @(negedge clk);
        while (!awready_o && n < 200) begin @(negedge clk); n++; end
        if (!awready_o) fail_now("aw_handshake");
        @(posedge clk); #1;
        awvalid_i = 1'b0;
    endtask

    task automatic w_xfer(input logic [31:0] data, input logic [3:0] strb, input bit last);
        int n = 0;
        wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
        @(negedge clk);
        while (!wready_o && n < 200) begin @(negedge clk); n++; end
        if (!wready_o) fail_now("w_handshake");
        @(posedge clk); #1;
        wvalid_i = 1'b0;
    endtask

    task automatic ar_xfer(input logic [3:0] id, input logic [31:0] addr);
        int n = 0;
        arid_i = id; araddr_i = addr; arvalid_i = 1'b1;
        @(negedge clk);
        while (!arready_o && n < 200) begin @(negedge clk); n++; end
        if (!arready_o) fail_now("ar_handshake");
        @(posedge clk); #1;
        arvalid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 500) begin
            @(posedge clk); n++;
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            fail_now(name);
            exp_b.delete();
            exp_r.delete();
        end
        #1;
    endtask

    task automatic write_pair(input logic [3:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb, input bit last);
        exp_write(id, addr, data, strb, last);
        fork
            aw_xfer(id, addr);
            w_xfer(data, strb, last);
        join
    endtask

    // Handshakes are sampled mid-cycle; the inputs are stable until the next rising edge.
    always @(negedge clk) begin
        if (!areset) begin
            if (bvalid_o && bready_i) begin
                if (exp_b.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    b_exp_t e;
                    e = exp_b.pop_front();
                    check("bid", 64'(bid_o), 64'(e.id));
                    check("bresp", 64'(bresp_o), 64'(e.resp));
                end
            end
            if (rvalid_o && rready_i) begin
                if (exp_r.size() == 0) begin
                    fail_now("r_unexpected");
                end else begin
                    r_exp_t e;
                    e = exp_r.pop_front();
                    check("rid", 64'(rid_o), 64'(e.id));
                    check("rdata", 64'(rdata_o), 64'(e.data));
                    check("rresp", 64'(rresp_o), 64'(e.resp));
                    check("rlast", 64'(rlast_o), 64'(1));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) begin
                bready_i = ($urandom_range(0, 3) != 0);
                rready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  id;
        int          sel;

        areset = 1'b1;
        awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
        wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
        arid_i = '0; araddr_i = '0; arvalid_i = 1'b0;
        bready_i = 1'b1; rready_i = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", 64'(bvalid_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_bid", 64'(bid_o), 64'(0));
        check("rst_rid", 64'(rid_o), 64'(0));
        check("rst_bresp", 64'(bresp_o), 64'(0));
        check("rst_rresp", 64'(rresp_o), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));
        check("rst_rlast", 64'(rlast_o), 64'(0));
        check("rst_awready", 64'(awready_o), 64'(1));
        check("rst_wready", 64'(wready_o), 64'(1));
        check("rst_arready", 64'(arready_o), 64'(1));
        areset = 1'b0;
        @(posedge clk); #1;

        // Same-cycle AW and W: response one edge after the handshake edge.
        write_pair(4'd3, 32'h8, 32'hDEADBEEF, 4'hF, 1'b1);
        @(posedge clk); #1;
        check("t1_bvalid", 64'(bvalid_o), 64'(1));
        check("t1_bid", 64'(bid_o), 64'(3));
        check("t1_bresp", 64'(bresp_o), 64'(0));
        wait_drain("t1_b");
        exp_read(4'd1, 32'h8);
        ar_xfer(4'd1, 32'h8);
        wait_drain("t1_r");

        // W arrives well ahead of AW; partial strobe merge.
        write_pair(4'd4, 32'h4, 32'h11223344, 4'hF, 1'b1);
        wait_drain("t2_init");
        exp_write(4'd7, 32'h4, 32'hAABBCCDD, 4'h5, 1'b1);
        w_xfer(32'hAABBCCDD, 4'h5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t2_bvalid_held", 64'(bvalid_o), 64'(0));
        check("t2_wready", 64'(wready_o), 64'(0));
        aw_xfer(4'd7, 32'h4);
        wait_drain("t2_b");
        exp_read(4'd2, 32'h4);
        ar_xfer(4'd2, 32'h4);
        wait_drain("t2_r");
        check("t2_model", 64'(mem[1]), 64'(32'h11BB33DD));

        // Out-of-range write and read.
        write_pair(4'd8, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b1);
        wait_drain("t3_b");
        exp_read(4'd9, 32'h40);
        ar_xfer(4'd9, 32'h40);
        wait_drain("t3_r");
        exp_read(4'd10, 32'h0);
        ar_xfer(4'd10, 32'h0);
        wait_drain("t3_r0");

        // B backpressure: second pair parks in the slots until bready rises.
        bready_i = 1'b0;
        write_pair(4'd5, 32'hC, 32'h0BADF00D, 4'hF, 1'b1);
        @(posedge clk); #1;
        check("t4_bvalid_first", 64'(bvalid_o), 64'(1));
        write_pair(4'd6, 32'h10, 32'hCAFEBABE, 4'hF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t4_awready", 64'(awready_o), 64'(0));
            check("t4_wready", 64'(wready_o), 64'(0));
            check("t4_bid_held", 64'(bid_o), 64'(5));
        end
        bready_i = 1'b1;
        @(posedge clk); #1;
        check("t4_bvalid_b2b", 64'(bvalid_o), 64'(1));
        check("t4_bid_second", 64'(bid_o), 64'(6));
        @(posedge clk); #1;
        check("t4_bvalid_clear", 64'(bvalid_o), 64'(0));
        wait_drain("t4_b");

        // Read and write commit on the same edge: pre-write data, then new data.
        write_pair(4'd1, 32'h8, 32'h5, 4'hF, 1'b1);
        wait_drain("t5_init");
        exp_read(4'd11, 32'h8);
        write_pair(4'd2, 32'h8, 32'h9, 4'hF, 1'b1);
        ar_xfer(4'd11, 32'h8);
        wait_drain("t5_same");
        exp_read(4'd12, 32'h8);
        ar_xfer(4'd12, 32'h8);
        wait_drain("t5_next");

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int it = 0; it < 150; it++) begin
            id   = 4'($urandom_range(0, 15));
            sel  = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, NUM_REGS - 1) * 4 + $urandom_range(0, 3));
            if (sel == 0) addr = 32'((NUM_REGS + $urandom_range(0, 7)) * 4);
            if (sel == 1) addr = addr | (32'h1 << $urandom_range(5, 31));
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] d;
                logic [3:0]  s;
                bit          l;
                int          da;
                int          dw;
                d  = $urandom;
                s  = 4'($urandom_range(0, 15));
                l  = ($urandom_range(0, 7) != 0);
                da = $urandom_range(0, 3);
                dw = $urandom_range(0, 3);
                exp_write(id, addr, d, s, l);
                fork
                    begin repeat (da) @(posedge clk); #1; aw_xfer(id, addr); end
                    begin repeat (dw) @(posedge clk); #1; w_xfer(d, s, l); end
                join
            end else begin
                exp_read(id, addr);
                ar_xfer(id, addr);
            end
            wait_drain("rand");
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        bready_i = 1'b1;
        rready_i = 1'b1;

        // Reset with both responses pending drops them and clears everything.
        bready_i = 1'b0;
        rready_i = 1'b0;
        write_pair(4'd13, 32'h0, 32'h12345678, 4'hF, 1'b1);
        exp_read(4'd14, 32'h0);
        ar_xfer(4'd14, 32'h0);
        check("t6_bvalid_pre", 64'(bvalid_o), 64'(1));
        check("t6_rvalid_pre", 64'(rvalid_o), 64'(1));
        areset = 1'b1;
        @(posedge clk); #1;
        check("t6_bvalid", 64'(bvalid_o), 64'(0));
        check("t6_rvalid", 64'(rvalid_o), 64'(0));
        check("t6_awready", 64'(awready_o), 64'(1));
        check("t6_wready", 64'(wready_o), 64'(1));
        check("t6_arready", 64'(arready_o), 64'(1));
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        areset = 1'b0;
        bready_i = 1'b1;
        rready_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_read(4'(i), 32'(i * 4));
            ar_xfer(4'(i), 32'(i * 4));
        end
        wait_drain("t6_reads");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
